// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Read-side controller for a synchronous FIFO with a registered read
//   pipeline. Watches the FIFO fill level, pops fixed-length bursts (or a
//   short burst of whatever is left after FLUSH), absorbs the FIFO read
//   latency in a small circular skid buffer and presents the words on a
//   valid/ready stream with a burst-last marker.
//
// Ports
//   CLK         sole clock, rising edge
//   RESET       synchronous, active-high reset
//   FIFO_EMPTY  FIFO empty flag
//   FIFO_RDCNT  words currently held in the FIFO
//   FIFO_Q      FIFO read data, valid RD_LATENCY cycles after FIFO_RE
//   FIFO_RE     FIFO read enable, one word per high cycle
//   FLUSH       pulse: drain a short burst when fewer than BURST_LEN remain
//   M_DATA      stream data (zero while M_VALID is low)
//   M_VALID     stream valid
//   M_READY     stream ready
//   M_LAST      final word of the current burst, qualified by M_VALID
//   BUSY        high while a burst is in progress or the buffer holds words
//   BURST_CNT   completed bursts, counted on the M_LAST handshake, wraps
module fifo_burst_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 10,
   parameter int RD_LATENCY = 2,
   parameter int BURST_LEN  = 16,
   parameter int SKID_DEPTH = 4
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  FIFO_EMPTY,
   input  logic [CNT_WIDTH-1:0]  FIFO_RDCNT,
   input  logic [DATA_WIDTH-1:0] FIFO_Q,
   output logic                  FIFO_RE,
   input  logic                  FLUSH,
   output logic [DATA_WIDTH-1:0] M_DATA,
   output logic                  M_VALID,
   input  logic                  M_READY,
   output logic                  M_LAST,
   output logic                  BUSY,
   output logic [15:0]           BURST_CNT
);

   localparam int OCC_W = $clog2(SKID_DEPTH + 1);
   localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
   localparam int IFL_W = $clog2(RD_LATENCY + 1);
   localparam int SUM_W = OCC_W + 1;

   typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

   state_t                  state;
   logic [CNT_WIDTH-1:0]    remaining;
   logic                    flush_pend;
   logic                    flush_active;

   logic [RD_LATENCY-1:0]   rd_vld_p;
   logic [RD_LATENCY-1:0]   rd_last_p;
   logic [IFL_W-1:0]        inflight;

   logic [DATA_WIDTH-1:0]   buf_data [SKID_DEPTH];
   logic [SKID_DEPTH-1:0]   buf_last;
   logic [PTR_W-1:0]        head;
   logic [PTR_W-1:0]        tail;
   logic [OCC_W-1:0]        occ;
   logic [15:0]             burst_cnt;

   logic                    re;
   logic                    credit_ok;
   logic                    push;
   logic                    pop;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++)
         inflight = inflight + IFL_W'(rd_vld_p[i]);
   end

   // Credit counts every requested word not yet popped, and ignores a
   // same-cycle pop so FIFO_RE never depends on M_READY.
   assign credit_ok = (SUM_W'(occ) + SUM_W'(inflight)) < SUM_W'(SKID_DEPTH);
   assign re        = (state == BURST) && (remaining != '0) && !FIFO_EMPTY && credit_ok;
   assign push      = rd_vld_p[RD_LATENCY-1];
   assign pop       = M_VALID && M_READY;

   assign FIFO_RE   = re;
   assign M_VALID   = (occ != '0);
   assign M_DATA    = M_VALID ? buf_data[head] : '0;
   assign M_LAST    = M_VALID && buf_last[head];
   assign BUSY      = (state != IDLE) || M_VALID;
   assign BURST_CNT = burst_cnt;

   // Burst control
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state        <= IDLE;
         remaining    <= '0;
         flush_pend   <= 1'b0;
         flush_active <= 1'b0;
      end else begin
         if (FLUSH && !flush_active)
            flush_pend <= 1'b1;
         case (state)
            IDLE: begin
               if (FIFO_RDCNT >= CNT_WIDTH'(BURST_LEN)) begin
                  state        <= BURST;
                  remaining    <= CNT_WIDTH'(BURST_LEN);
                  flush_pend   <= 1'b0;
                  flush_active <= 1'b0;
               end else if (flush_pend && (FIFO_RDCNT != '0)) begin
                  state        <= BURST;
                  remaining    <= FIFO_RDCNT;
                  flush_pend   <= 1'b0;
                  flush_active <= 1'b1;
               end
            end
            BURST: begin
               if (re) begin
                  remaining <= remaining - 1'b1;
                  if (remaining == CNT_WIDTH'(1))
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               if (inflight == '0) begin
                  state        <= IDLE;
                  flush_active <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read pipeline: mirrors the FIFO read latency, one stage per cycle
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rd_vld_p <= '0;
      end else begin
         rd_vld_p[0] <= re;
         for (int i = 1; i < RD_LATENCY; i++)
            rd_vld_p[i] <= rd_vld_p[i-1];
      end
   end

   always_ff @(posedge CLK) begin
      rd_last_p[0] <= re && (remaining == CNT_WIDTH'(1));
      for (int i = 1; i < RD_LATENCY; i++)
         rd_last_p[i] <= rd_last_p[i-1];
   end

   // Skid buffer: capture at the pipeline output, pop at the stream handshake
   always_ff @(posedge CLK) begin
      if (push) begin
         buf_data[tail] <= FIFO_Q;
         buf_last[tail] <= rd_last_p[RD_LATENCY-1];
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         head      <= '0;
         tail      <= '0;
         occ       <= '0;
         burst_cnt <= '0;
      end else begin
         if (push)
            tail <= ptr_next(tail);
         if (pop)
            head <= ptr_next(head);
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
         if (pop && M_LAST)
            burst_cnt <= burst_cnt + 16'd1;
      end
   end

   a_no_overflow: assert property (@(posedge CLK) disable iff (RESET)
      !(push && !pop && (occ == OCC_W'(SKID_DEPTH))));

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader
//   Directed bench for fifo_burst_reader with a behavioural 2-cycle-latency
//   FIFO model, a stream monitor and hand-computed expected values.
module tb_fifo_burst_reader;

   logic        clk;
   logic        reset;
   logic        fifo_empty;
   logic [9:0]  fifo_rdcnt;
   logic [31:0] fifo_q;
   logic        fifo_re;
   logic        flush;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;
   logic        busy;
   logic [15:0] burst_cnt;

   int n_checks;
   int n_pass;

   fifo_burst_reader dut (
      .CLK        (clk),
      .RESET      (reset),
      .FIFO_EMPTY (fifo_empty),
      .FIFO_RDCNT (fifo_rdcnt),
      .FIFO_Q     (fifo_q),
      .FIFO_RE    (fifo_re),
      .FLUSH      (flush),
      .M_DATA     (m_data),
      .M_VALID    (m_valid),
      .M_READY    (m_ready),
      .M_LAST     (m_last),
      .BUSY       (busy),
      .BURST_CNT  (burst_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // FIFO model: data appears on fifo_q two cycles after the read cycle
   logic [31:0] fmem [0:1023];
   int          wr_ptr;
   int          rd_ptr;
   logic [31:0] q_p0;
   logic [31:0] q_p1;

   always @(posedge clk) begin
      if (reset) begin
         rd_ptr <= wr_ptr;
      end else if (fifo_re && (wr_ptr != rd_ptr)) begin
         q_p0   <= fmem[rd_ptr % 1024];
         rd_ptr <= rd_ptr + 1;
      end
      q_p1 <= q_p0;
   end

   assign fifo_q     = q_p1;
   assign fifo_rdcnt = 10'(wr_ptr - rd_ptr);
   assign fifo_empty = (wr_ptr == rd_ptr);

   // Stream / read-enable monitor
   logic [31:0] beat_data [$];
   logic        beat_last [$];
   int          re_total;
   int          re_run;
   int          re_last_run;

   always @(negedge clk) begin
      if (!reset) begin
         if (m_valid && m_ready) begin
            beat_data.push_back(m_data);
            beat_last.push_back(m_last);
         end
         if (fifo_re) begin
            re_total++;
            re_run++;
         end else if (re_run != 0) begin
            re_last_run = re_run;
            re_run      = 0;
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic preload(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         fmem[wr_ptr % 1024] = base + 32'(i);
         wr_ptr++;
      end
   endtask

   task automatic wait_beats(input int target, input int budget);
      int k;
      k = 0;
      while ((beat_data.size() < target) && (k < budget)) begin
         tick(1);
         k++;
      end
      if (beat_data.size() < target)
         check_val("beat_timeout", 32'(beat_data.size()), 32'(target));
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while (busy && (k < budget)) begin
         tick(1);
         k++;
      end
      if (busy)
         check_val("idle_timeout", {31'b0, busy}, 32'd0);
   endtask

   task automatic check_burst(input string tag, input int base, input int n, input logic [31:0] val0);
      for (int i = 0; i < n; i++) begin
         check_val($sformatf("%s_data%0d", tag, i), beat_data[base + i], val0 + 32'(i));
         check_val($sformatf("%s_last%0d", tag, i), {31'b0, beat_last[base + i]},
                   (i == n - 1) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int re0;
      int nl;

      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b1;
      flush    = 1'b0;
      m_ready  = 1'b1;

      // Reset state
      tick(2);
      check_val("rst_re",    {31'b0, fifo_re}, 32'd0);
      check_val("rst_valid", {31'b0, m_valid}, 32'd0);
      check_val("rst_last",  {31'b0, m_last},  32'd0);
      check_val("rst_data",  m_data,           32'd0);
      check_val("rst_busy",  {31'b0, busy},    32'd0);
      check_val("rst_cnt",   {16'b0, burst_cnt}, 32'd0);
      reset = 1'b0;
      tick(1);

      // T1: one full burst at full rate
      do_reset();
      base = beat_data.size();
      re0  = re_total;
      preload(16, 32'h0);
      wait_beats(base + 16, 200);
      tick(3);
      wait_idle(50);
      check_burst("t1", base, 16, 32'h0);
      check_val("t1_cnt",     {16'b0, burst_cnt}, 32'd1);
      check_val("t1_busy",    {31'b0, busy},      32'd0);
      check_val("t1_re_tot",  32'(re_total - re0), 32'd16);
      check_val("t1_re_run",  32'(re_last_run),    32'd16);
      check_val("t1_fifo",    {22'b0, fifo_rdcnt}, 32'd0);

      // T2: short residue only leaves on FLUSH
      do_reset();
      base = beat_data.size();
      re0  = re_total;
      preload(10, 32'h100);
      tick(50);
      check_val("t2_no_re",   32'(re_total - re0), 32'd0);
      check_val("t2_idle",    {31'b0, busy},       32'd0);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      wait_beats(base + 10, 200);
      tick(3);
      wait_idle(50);
      check_burst("t2", base, 10, 32'h100);
      check_val("t2_cnt",     {16'b0, burst_cnt},  32'd1);
      check_val("t2_re_tot",  32'(re_total - re0), 32'd10);

      // T3: consumer stall bounds outstanding reads and holds the head word
      do_reset();
      m_ready = 1'b0;
      base = beat_data.size();
      re0  = re_total;
      preload(16, 32'h500);
      for (int k = 0; (k < 100) && !m_valid; k++)
         tick(1);
      check_val("t3_valid", {31'b0, m_valid}, 32'd1);
      for (int c = 0; c < 20; c++) begin
         if ((c % 5) == 0) begin
            check_val($sformatf("t3_hold%0d", c), m_data, 32'h500);
            check_val($sformatf("t3_vld%0d", c), {31'b0, m_valid}, 32'd1);
         end
         tick(1);
      end
      check_val("t3_re_out", 32'(re_total - re0), 32'd4);
      check_val("t3_fifo",   {22'b0, fifo_rdcnt}, 32'd12);
      m_ready = 1'b1;
      wait_beats(base + 16, 300);
      tick(3);
      wait_idle(50);
      check_burst("t3", base, 16, 32'h500);
      check_val("t3_cnt", {16'b0, burst_cnt}, 32'd1);

      // T4: 40 words give exactly two bursts, 8 words stay behind
      do_reset();
      base = beat_data.size();
      re0  = re_total;
      preload(40, 32'h200);
      wait_beats(base + 32, 400);
      tick(3);
      wait_idle(50);
      tick(20);
      check_val("t4_busy",   {31'b0, busy},       32'd0);
      check_val("t4_beats",  32'(beat_data.size() - base), 32'd32);
      check_val("t4_re_tot", 32'(re_total - re0), 32'd32);
      check_val("t4_fifo",   {22'b0, fifo_rdcnt}, 32'd8);
      check_val("t4_cnt",    {16'b0, burst_cnt},  32'd2);
      nl = 0;
      for (int i = 0; i < 32; i++)
         nl += int'(beat_last[base + i]);
      check_val("t4_nlast", 32'(nl), 32'd2);
      check_burst("t4a", base,      16, 32'h200);
      check_burst("t4b", base + 16, 16, 32'h210);

      // T5: reset after the 5th beat discards the rest of the burst
      do_reset();
      base = beat_data.size();
      preload(16, 32'h300);
      wait_beats(base + 5, 200);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check_val("t5_valid", {31'b0, m_valid},  32'd0);
      check_val("t5_re",    {31'b0, fifo_re},  32'd0);
      check_val("t5_busy",  {31'b0, busy},     32'd0);
      check_val("t5_cnt",   {16'b0, burst_cnt}, 32'd0);
      check_val("t5_beats", 32'(beat_data.size() - base), 32'd5);
      tick(10);
      check_val("t5_quiet", 32'(beat_data.size() - base), 32'd5);
      base = beat_data.size();
      preload(16, 32'h400);
      wait_beats(base + 16, 200);
      tick(3);
      wait_idle(50);
      check_burst("t5", base, 16, 32'h400);
      check_val("t5_cnt2", {16'b0, burst_cnt}, 32'd1);

      // T6: burst counter wraps from 0xFFFF to 0
      do_reset();
      force dut.burst_cnt = 16'hFFFF;
      tick(1);
      release dut.burst_cnt;
      tick(1);
      check_val("t6_pre", {16'b0, burst_cnt}, 32'h0000FFFF);
      base = beat_data.size();
      preload(16, 32'h600);
      wait_beats(base + 16, 200);
      tick(3);
      wait_idle(50);
      check_val("t6_wrap", {16'b0, burst_cnt}, 32'd0);
      check_burst("t6", base, 16, 32'h600);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
